// File: rtl/axi_read_burst_ctrl_pkg.sv
// axi_read_burst_ctrl_pkg: shared state encoding, default geometry and helpers for the AXI read burst controller
package axi_read_burst_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
  localparam int LP_DATA_WIDTH      = 512;
  localparam int LP_BURST_LEN       = 64;
  localparam int LP_MAX_OUTSTANDING = 16;
  localparam int LP_BPB             = LP_DATA_WIDTH / 8;
  localparam int LP_LOG_BPB         = $clog2(LP_BPB);
  localparam int LP_BURST_BYTES     = LP_BURST_LEN * LP_BPB;
  localparam int LP_OUTSTANDING_W   = $clog2(LP_MAX_OUTSTANDING + 1);
  function automatic logic [63:0] ceil_div(input logic [63:0] n, input logic [63:0] d);
    return (n + d - 64'd1) / d;
  endfunction
endpackage

// File: rtl/axi_read_burst_splitter.sv
// axi_read_burst_splitter: holds the burst address, remaining-burst count and last-burst length
module axi_read_burst_splitter
  import axi_read_burst_ctrl_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_BURST_BYTES     = 4096,
  parameter int C_LOG_BPB         = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic                         i_advance,
  input  logic [C_ADDR_WIDTH-1:0]      i_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] i_total_beats,
  output logic [C_ADDR_WIDTH-1:0]      o_araddr,
  output logic [7:0]                   o_arlen,
  output logic                         o_last_burst
);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = ~C_ADDR_WIDTH'((1 << C_LOG_BPB) - 1);
  logic [C_ADDR_WIDTH-1:0]      r_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] r_bursts_rem;
  logic [C_XFER_SIZE_WIDTH-1:0] w_bursts;
  logic [8:0]                   r_last_len;
  logic [8:0]                   w_last_len;
  always_comb begin
    w_bursts     = C_XFER_SIZE_WIDTH'(ceil_div(64'(i_total_beats), 64'(C_BURST_LEN)));
    w_last_len   = 9'(i_total_beats - (w_bursts - C_XFER_SIZE_WIDTH'(1)) * C_XFER_SIZE_WIDTH'(C_BURST_LEN));
    o_last_burst = r_bursts_rem == C_XFER_SIZE_WIDTH'(1);
    o_araddr     = r_addr;
    // arlen reads 0 whenever no burst is pending, including straight out of reset
    o_arlen      = r_bursts_rem == '0 ? 8'd0 : o_last_burst ? 8'(r_last_len - 9'd1) : 8'(C_BURST_LEN - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr       <= '0;
      r_bursts_rem <= '0;
      r_last_len   <= '0;
    end else if (i_load) begin
      r_addr       <= i_addr & ADDR_MASK;
      r_bursts_rem <= w_bursts;
      r_last_len   <= w_last_len;
    end else if (i_advance) begin
      r_addr       <= r_addr + C_ADDR_WIDTH'(C_BURST_BYTES);
      r_bursts_rem <= r_bursts_rem - C_XFER_SIZE_WIDTH'(1);
    end
endmodule

// File: rtl/axi_read_burst_ctrl.sv
// axi_read_burst_ctrl: splits a kernel read request into AXI4 bursts, bounds outstanding bursts and forwards R beats to AXI4-Stream
module axi_read_burst_ctrl
  import axi_read_burst_ctrl_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  output logic                         ctrl_done,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                         m_axi_rlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                         m_axis_tlast
);
  localparam int BPB         = C_DATA_WIDTH / 8;
  localparam int LOG_BPB     = $clog2(BPB);
  localparam int BURST_BYTES = C_BURST_LEN * BPB;
  localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING + 1);
  state_e                       r_state;
  state_e                       w_next;
  logic [C_XFER_SIZE_WIDTH-1:0] r_beats_rem;
  logic [C_XFER_SIZE_WIDTH-1:0] w_total_beats;
  logic [OUT_W-1:0]             r_outstanding;
  logic                         w_active;
  logic                         w_start;
  logic                         w_ar_hs;
  logic                         w_beat;
  logic                         w_rlast_acc;
  logic                         w_last_burst;
  always_comb begin
    w_total_beats = C_XFER_SIZE_WIDTH'(ceil_div(64'(ctrl_xfer_size_in_bytes), 64'(BPB)));
    w_start       = r_state == IDLE && ctrl_start;
    // a zero-length request passes through DRAIN with nothing to accept, so keep rready low there
    w_active      = (r_state == ISSUE || r_state == DRAIN) && r_beats_rem != '0;
    m_axi_arvalid = r_state == ISSUE && r_outstanding < OUT_W'(C_MAX_OUTSTANDING);
    w_ar_hs       = m_axi_arvalid && m_axi_arready;
    m_axi_rready  = w_active && m_axis_tready;
    m_axis_tvalid = w_active && m_axi_rvalid;
    m_axis_tdata  = m_axi_rdata;
    m_axis_tlast  = r_beats_rem == C_XFER_SIZE_WIDTH'(1);
    w_beat        = m_axis_tvalid && m_axis_tready;
    w_rlast_acc   = w_beat && m_axi_rlast && r_outstanding != '0;
    ctrl_done     = r_state == DONE;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !ctrl_start ? IDLE : w_total_beats == '0 ? DRAIN : ISSUE;
      ISSUE:   w_next = w_ar_hs && w_last_burst ? DRAIN : ISSUE;
      DRAIN:   w_next = r_beats_rem == '0 || (w_beat && r_beats_rem == C_XFER_SIZE_WIDTH'(1)) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_beats_rem   <= '0;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_next;
      r_beats_rem   <= w_start ? w_total_beats : r_beats_rem - C_XFER_SIZE_WIDTH'(w_beat);
      r_outstanding <= r_outstanding + OUT_W'(w_ar_hs) - OUT_W'(w_rlast_acc);
    end
  axi_read_burst_splitter #(
    .C_ADDR_WIDTH     (C_ADDR_WIDTH),
    .C_XFER_SIZE_WIDTH(C_XFER_SIZE_WIDTH),
    .C_BURST_LEN      (C_BURST_LEN),
    .C_BURST_BYTES    (BURST_BYTES),
    .C_LOG_BPB        (LOG_BPB)
  ) u_splitter (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_start),
    .i_advance    (w_ar_hs),
    .i_addr       (ctrl_addr_offset),
    .i_total_beats(w_total_beats),
    .o_araddr     (m_axi_araddr),
    .o_arlen      (m_axi_arlen),
    .o_last_burst (w_last_burst)
  );
endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// tb_axi_read_burst_ctrl: random AXI slave and stream sink scored against a transfer-level model of the controller
module tb_axi_read_burst_ctrl;
  import axi_read_burst_ctrl_pkg::*;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = 32;
  localparam int BL = 64;
  localparam int MO = 2;
  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_start;
  logic          ctrl_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [SW-1:0] ctrl_xfer_size_in_bytes;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  always #5 clk = ~clk;
  axi_read_burst_ctrl #(
    .C_ADDR_WIDTH     (AW),
    .C_DATA_WIDTH     (DW),
    .C_XFER_SIZE_WIDTH(SW),
    .C_BURST_LEN      (BL),
    .C_MAX_OUTSTANDING(MO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ctrl_start             (ctrl_start),
    .ctrl_done              (ctrl_done),
    .ctrl_addr_offset       (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .m_axi_arvalid          (m_axi_arvalid),
    .m_axi_arready          (m_axi_arready),
    .m_axi_araddr           (m_axi_araddr),
    .m_axi_arlen            (m_axi_arlen),
    .m_axi_rvalid           (m_axi_rvalid),
    .m_axi_rready           (m_axi_rready),
    .m_axi_rdata            (m_axi_rdata),
    .m_axi_rlast            (m_axi_rlast),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_tdata           (m_axis_tdata),
    .m_axis_tlast           (m_axis_tlast)
  );
  int n_cmp = 0;
  int n_bad = 0;
  // model of the transfer in flight
  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];
  bit            busy = 0;
  int            outst = 0;
  int            total = 0;
  int            beats_got = 0;
  int            done_at = -1;
  int            cyc = 0;
  // slave side: bursts accepted and not yet fully returned
  logic [AW-1:0] rq_addr[$];
  int            rq_len[$];
  int            r_beat = 0;
  int            p_ar, p_rv, p_tr, rv_hold, ar_hold, run_n;
  bit            spur;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic knobs(input int ar, input int rv, input int tr, input int rvh, input int arh, input bit sp);
    p_ar = ar; p_rv = rv; p_tr = tr; rv_hold = rvh; ar_hold = arh; spur = sp;
  endtask
  task automatic cycle(input bit st);
    bit            exp_arv, ar_hs, r_hs, rl;
    logic [AW-1:0] ar_a;
    int            ar_l;
    m_axi_arready = run_n >= ar_hold && $urandom_range(99) < p_ar;
    m_axi_rvalid  = run_n >= rv_hold && rq_addr.size() != 0 && $urandom_range(99) < p_rv;
    m_axi_rlast   = rq_addr.size() != 0 && r_beat == rq_len[0];
    m_axis_tready = $urandom_range(99) < p_tr;
    for (int i = 0; i < DW / 32; i++) m_axi_rdata[i*32 +: 32] = $urandom;
    ctrl_start = st;
    if (!st && busy && spur && $urandom_range(15) == 0) begin
      ctrl_start = 1'b1;
      ctrl_addr_offset = {$urandom, $urandom};
      ctrl_xfer_size_in_bytes = $urandom;
    end
    #1;
    exp_arv = busy && exp_addr.size() != 0 && outst < MO;
    chk("arvalid", m_axi_arvalid, exp_arv);
    if (exp_arv) begin
      chk("araddr", m_axi_araddr, exp_addr[0]);
      chk("arlen", m_axi_arlen, exp_len[0]);
    end
    chk("rready", m_axi_rready, busy && m_axis_tready);
    chk("tvalid", m_axis_tvalid, busy && m_axi_rvalid);
    if (m_axis_tvalid) begin
      chk("tdata", m_axis_tdata, m_axi_rdata);
      chk("tlast", m_axis_tlast, beats_got == total - 1);
    end
    chk("done", ctrl_done, cyc == done_at);
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs  = m_axi_rvalid && m_axi_rready;
    rl    = m_axi_rlast;
    ar_a  = m_axi_araddr;
    ar_l  = m_axi_arlen;
    @(posedge clk);
    cyc++;
    if (ar_hs) begin
      rq_addr.push_back(ar_a);
      rq_len.push_back(ar_l);
      if (exp_addr.size() != 0) begin
        exp_addr.delete(0);
        exp_len.delete(0);
      end
      outst++;
    end
    if (r_hs) begin
      beats_got++;
      if (rl) begin
        rq_addr.delete(0);
        rq_len.delete(0);
        r_beat = 0;
        outst--;
      end else r_beat++;
      if (busy && beats_got == total) begin
        busy = 0;
        done_at = cyc;
      end
    end
    if (st) begin
      busy = total != 0;
      if (total == 0) done_at = cyc + 1;
    end
    run_n++;
    @(negedge clk);
  endtask
  task automatic run_xfer(input logic [AW-1:0] addr, input logic [SW-1:0] size, input int abort_at);
    int nb;
    total = int'((longint'(size) + LP_BPB - 1) / LP_BPB);
    nb = (total + BL - 1) / BL;
    for (int b = 0; b < nb; b++) begin
      exp_addr.push_back((addr & ~64'(LP_BPB - 1)) + 64'(longint'(b) * LP_BURST_BYTES));
      exp_len.push_back(b == nb - 1 ? total - b * BL - 1 : BL - 1);
    end
    beats_got = 0;
    done_at = -1;
    run_n = 0;
    ctrl_addr_offset = addr;
    ctrl_xfer_size_in_bytes = size;
    cycle(1'b1);
    while (!(done_at >= 0 && cyc > done_at) && run_n < 6000) begin
      if (rv_hold > 0 && run_n == rv_hold) chk("ar_cap", rq_addr.size(), MO);
      cycle(1'b0);
      if (abort_at > 0 && beats_got >= abort_at) return;
    end
    chk("finished", done_at >= 0 && cyc > done_at, 1);
    chk("ar_left", exp_addr.size(), 0);
    chk("beats", beats_got, total);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, ctrl_done, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
  endtask
  initial begin
    rst = 1'b1;
    ctrl_start = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_rlast = 1'b0;
    m_axis_tready = 1'b0;
    knobs(100, 100, 100, 0, 0, 0);
    run_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_axi_rvalid = 1'b1;
    m_axis_tready = 1'b1;
    m_axi_arready = 1'b1;
    #1;
    chk_idle_outputs("por");
    rst = 1'b0;
    m_axi_rvalid = 1'b0;
    @(negedge clk);
    run_xfer(64'h1000_0000, 8192, 0);
    run_xfer(64'h0, 100, 0);
    run_xfer(64'h0, 0, 0);
    knobs(100, 100, 100, 12, 0, 0);
    run_xfer(64'h2000_0000, 65536, 0);
    knobs(60, 70, 80, 0, 0, 1);
    run_xfer(64'h2100_0000, 65536, 0);
    knobs(100, 100, 50, 0, 6, 0);
    run_xfer(64'h3000_0000, 8192, 0);
    knobs(100, 100, 100, 0, 0, 0);
    run_xfer(64'h1000_0000, 8192, 3);
    m_axi_rvalid = 1'b1;
    m_axi_arready = 1'b1;
    m_axis_tready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy = 0;
    outst = 0;
    total = 0;
    beats_got = 0;
    done_at = -1;
    exp_addr.delete();
    exp_len.delete();
    repeat (3) cycle(1'b0);
    rq_addr.delete();
    rq_len.delete();
    r_beat = 0;
    run_xfer(64'h4000_0000, 64, 0);
    for (int k = 0; k < 16; k++) begin
      logic [SW-1:0] sz;
      logic [AW-1:0] ad;
      sz = $urandom_range(0, 3) == 0 ? SW'($urandom_range(0, 8) * 4096) : SW'($urandom_range(0, 20000));
      ad = (64'($urandom_range(0, 65535)) << 12) | 64'($urandom_range(0, 63));
      knobs($urandom_range(50, 100), $urandom_range(50, 100), $urandom_range(50, 100), 0, 0, 1);
      run_xfer(ad, sz, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
